// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO, issue sequencer and result holder around a combinational ALU
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_op,
    output logic        res_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_BAD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [66:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] wait_cnt;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   head_a;
    logic [31:0]   head_b;
    logic [2:0]    head_op;
    logic          head_illegal;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = cmd_valid && !full;
    assign pop     = (state == IDLE) && !empty;
    assign head_a  = mem[rd_ptr][66:35];
    assign head_b  = mem[rd_ptr][34:3];
    assign head_op = mem[rd_ptr][2:0];
    // Illegal opcodes and divide-by-zero never reach the ALU inputs.
    assign head_illegal = (head_op == OP_BAD) || ((head_op == OP_DIV) && (head_b == '0));

    // FIFO storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // FIFO pointers and occupancy; full blocks push regardless of a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: trapped commands skip EXEC and go straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = head_illegal ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (wait_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state and FIFO occupancy.
    always_comb begin
        cmd_ready = !full;
        res_valid = (state == DONE);
        busy      = (state != IDLE) || !empty;
    end

    // Datapath: issue registers, settle counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            wait_cnt <= '0;
            res_data <= '0;
            res_op   <= '0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_illegal) begin
                            res_data <= '0;
                            res_op   <= head_op;
                            res_err  <= 1'b1;
                        end else begin
                            alu_a    <= head_a;
                            alu_b    <= head_b;
                            alu_op   <= head_op;
                            wait_cnt <= CW'(ALU_LAT - 1);
                        end
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        res_data <= alu_result;
                        res_op   <= alu_op;
                        res_err  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
